// File: rtl/sm_mem_pkg.sv
// sm_mem_pkg: constants shared by the SRAM request controller and its
// response queue.
//   RESP_Q_DEPTH  - number of read responses the controller may hold (3)
//   WEN_WRITE/READ - encoding of the req_wen request-type bit
//   q_ptr_inc()   - queue pointer increment, wrapping modulo RESP_Q_DEPTH
package sm_mem_pkg;

  localparam int unsigned RESP_Q_DEPTH = 3;
  localparam int unsigned RESP_Q_PTR_W = 2;
  // Count must reach RESP_Q_DEPTH itself, so 2 bits for a depth of 3.
  localparam int unsigned RESP_Q_CNT_W = 2;

  localparam logic WEN_WRITE = 1'b1;
  localparam logic WEN_READ  = 1'b0;

  // Depth is not a power of two, so wrap explicitly.
  function automatic logic [RESP_Q_PTR_W-1:0] q_ptr_inc(input logic [RESP_Q_PTR_W-1:0] p);
    return (p == RESP_Q_PTR_W'(RESP_Q_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/sm_resp_queue.sv
// sm_resp_queue: RESP_Q_DEPTH-entry FIFO holding SRAM read data until the
// consumer takes it.
//   clk, reset      - clock, synchronous active-high reset
//   i_enq/i_enq_data - push one word (caller guarantees not full)
//   o_val/i_rdy/o_data - valid/ready pop side; data held while stalled
//   o_count         - current occupancy, used upstream for flow control
module sm_resp_queue
  import sm_mem_pkg::*;
#(
  parameter int p_wid = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_enq,
  input  logic [p_wid-1:0]        i_enq_data,
  output logic                    o_val,
  input  logic                    i_rdy,
  output logic [p_wid-1:0]        o_data,
  output logic [RESP_Q_CNT_W-1:0] o_count
);

  logic [p_wid-1:0]        r_mem [RESP_Q_DEPTH];
  logic [RESP_Q_PTR_W-1:0] r_wptr, r_rptr;
  logic [RESP_Q_CNT_W-1:0] r_count;
  logic                    w_deq;

  // Valid is masked by reset so the consumer sees nothing during reset,
  // even in the first reset cycle before the count has cleared.
  assign o_val   = (r_count != '0) && !reset;
  assign w_deq   = o_val && i_rdy;
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

  // Data storage needs no reset; occupancy tracking decides what is live.
  always_ff @(posedge clk) begin
    if (i_enq) r_mem[r_wptr] <= i_enq_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_enq) r_wptr <= q_ptr_inc(r_wptr);
      if (w_deq) r_rptr <= q_ptr_inc(r_rptr);
      case ({i_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(i_enq && (r_count == RESP_Q_CNT_W'(RESP_Q_DEPTH))))
    else $error("sm_resp_queue: enqueue while full");
`endif

endmodule

// File: rtl/sm_mem_req_ctrl.sv
// sm_mem_req_ctrl: valid/ready front end for a single-port, non-pipelined
// SRAM. Writes complete silently; reads return data in order through a
// small response queue with a fixed two-cycle minimum latency.
//   clk, reset                      - clock, synchronous active-high reset
//   req_val/req_rdy/req_wen/req_addr/req_data - request channel (wen 1=write)
//   resp_val/resp_rdy/resp_data     - read response channel
//   sram_cen/sram_rwen/sram_a/sram_d - SRAM command (active-low enables)
//   sram_q                          - SRAM read data, valid one cycle after issue
module sm_mem_req_ctrl
  import sm_mem_pkg::*;
#(
  parameter  int p_wid   = 64,
  parameter  int p_dep   = 64,
  localparam int lp_awid = $clog2(p_dep)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic               req_wen,
  input  logic [lp_awid-1:0] req_addr,
  input  logic [p_wid-1:0]   req_data,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [p_wid-1:0]   resp_data,
  output logic               sram_cen,
  output logic               sram_rwen,
  output logic [lp_awid-1:0] sram_a,
  output logic [p_wid-1:0]   sram_d,
  input  logic [p_wid-1:0]   sram_q
);

  logic                    w_fire;
  logic                    w_rd_fire;
  logic                    r_inflight;
  logic [RESP_Q_CNT_W-1:0] w_count;
  logic [RESP_Q_CNT_W:0]   w_occ;

  // Every accepted read owns a queue slot from issue until dequeue, so the
  // in-flight read counts against capacity; this is what rules out overflow.
  assign w_occ   = (RESP_Q_CNT_W+1)'(r_inflight) + (RESP_Q_CNT_W+1)'(w_count);
  assign req_rdy = !reset && (w_occ < (RESP_Q_CNT_W+1)'(RESP_Q_DEPTH));

  assign w_fire    = req_val && req_rdy;
  assign w_rd_fire = w_fire && (req_wen == WEN_READ);

  // SRAM is driven straight from the request; chip enable gates the access.
  assign sram_cen  = !w_fire;
  assign sram_rwen = !req_wen;
  assign sram_a    = req_addr;
  assign sram_d    = req_data;

  // sram_q is valid in the cycle after a read issue; this flag marks it.
  always_ff @(posedge clk) begin
    if (reset) r_inflight <= 1'b0;
    else       r_inflight <= w_rd_fire;
  end

  sm_resp_queue #(
    .p_wid (p_wid)
  ) u_resp_q (
    .clk        (clk),
    .reset      (reset),
    .i_enq      (r_inflight),
    .i_enq_data (sram_q),
    .o_val      (resp_val),
    .i_rdy      (resp_rdy),
    .o_data     (resp_data),
    .o_count    (w_count)
  );

endmodule
